// File: rtl/pmesh_l1_fwd_responder_if.sv
// pmesh_l1_fwd_responder_if
//   Groups the three handshake channels of the L1 forward responder:
//     msg2_* : L2-to-L1 forward request (valid/ready, type, tag)
//     msg3_* : L1-to-L2 forward ack (valid/ready, type, tag, source, data)
//     fill_* : local line install (valid/ready, tag, data, state)
//   Modports:
//     slave  : the responder (consumes msg2/fill, produces msg3)
//     master : the L2 / fill side driving the responder
interface pmesh_l1_fwd_responder_if;
    logic        msg2_valid;
    logic        msg2_ready;
    logic [7:0]  msg2_type;
    logic [25:0] msg2_tag;

    logic        msg3_valid;
    logic        msg3_ready;
    logic [7:0]  msg3_type;
    logic [25:0] msg3_tag;
    logic [5:0]  msg3_source;
    logic [63:0] msg3_data;

    logic        fill_valid;
    logic        fill_ready;
    logic [25:0] fill_tag;
    logic [63:0] fill_data;
    logic [1:0]  fill_state;

    modport slave (
        input  msg2_valid, msg2_type, msg2_tag,
        output msg2_ready,
        output msg3_valid, msg3_type, msg3_tag, msg3_source, msg3_data,
        input  msg3_ready,
        input  fill_valid, fill_tag, fill_data, fill_state,
        output fill_ready
    );

    modport master (
        output msg2_valid, msg2_type, msg2_tag,
        input  msg2_ready,
        input  msg3_valid, msg3_type, msg3_tag, msg3_source, msg3_data,
        output msg3_ready,
        output fill_valid, fill_tag, fill_data, fill_state,
        input  fill_ready
    );
endinterface

// File: rtl/pmesh_l1_fwd_responder.sv
// pmesh_l1_fwd_responder
//   Single-line L1 model that answers L2 forward requests. A STORE_FWD
//   returns the line data on a hit and invalidates the line; a miss returns
//   zero data and leaves the line alone. Unsupported request types are
//   accepted and flagged with a one-cycle err_pulse, without an ack.
//   Forward requests take priority over local fills.
//
//   Optional feature: define PMESH_L1_LOAD_FWD_EN to answer LOAD_FWD with
//   LOAD_FWDACK (data on a hit, line downgraded to S). Without the macro,
//   LOAD_FWD is treated as an unsupported type.
//
//   Ports:
//     clk        : clock, all state on posedge
//     rst        : asynchronous active-high reset
//     bus        : msg2 / msg3 / fill channels (slave modport)
//     line_state : current state of the held line (I=0 S=1 E=2 M=3)
//     err_pulse  : one-cycle pulse after an unsupported request is accepted
//
//   FSM:
//     state | meaning
//     IDLE  | accepting forward requests (and fills when no request waits)
//     RESP  | ack presented on msg3, waiting for msg3_ready
module pmesh_l1_fwd_responder #(
    parameter logic [5:0] NODE_ID = 6'd0
) (
    input  logic                           clk,
    input  logic                           rst,
    pmesh_l1_fwd_responder_if.slave        bus,
    output logic [1:0]                     line_state,
    output logic                           err_pulse
);

    localparam logic [7:0] STORE_FWD    = 8'h15;
    localparam logic [7:0] STORE_FWDACK = 8'h16;
    localparam logic [1:0] ST_I         = 2'd0;
`ifdef PMESH_L1_LOAD_FWD_EN
    localparam logic [7:0] LOAD_FWD     = 8'h13;
    localparam logic [7:0] LOAD_FWDACK  = 8'h14;
    localparam logic [1:0] ST_S         = 2'd1;
`endif

    typedef enum logic {
        IDLE = 1'b0,
        RESP = 1'b1
    } state_t;

    state_t      state_q, state_d;

    logic [25:0] line_tag_q;
    logic [63:0] line_data_q;
    logic [1:0]  line_state_q;

    logic [7:0]  msg3_type_q;
    logic [25:0] msg3_tag_q;
    logic [63:0] msg3_data_q;
    logic        err_q;

    logic        is_store;
    logic        supported;
    logic        hit;
    logic        req_fire;
    logic        fill_fire;
    logic [7:0]  ack_type;
    logic [1:0]  hit_next_state;

    assign is_store = (bus.msg2_type == STORE_FWD);

`ifdef PMESH_L1_LOAD_FWD_EN
    assign supported      = is_store || (bus.msg2_type == LOAD_FWD);
    assign ack_type       = is_store ? STORE_FWDACK : LOAD_FWDACK;
    assign hit_next_state = is_store ? ST_I : ST_S;
`else
    assign supported      = is_store;
    assign ack_type       = STORE_FWDACK;
    assign hit_next_state = ST_I;
`endif

    assign hit = (line_state_q != ST_I) && (bus.msg2_tag == line_tag_q);

    // Handshakes are derived from the registered state rather than from the
    // ready outputs, keeping the combinational paths acyclic. rst gates both
    // readies so nothing is accepted while reset is held.
    assign req_fire  = (state_q == IDLE) && !rst && bus.msg2_valid;
    assign fill_fire = (state_q == IDLE) && !rst && !bus.msg2_valid && bus.fill_valid;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d         = state_q;
        bus.msg2_ready  = 1'b0;
        bus.fill_ready  = 1'b0;
        bus.msg3_valid  = 1'b0;
        case (state_q)
            IDLE: begin
                bus.msg2_ready = !rst;
                bus.fill_ready = !rst && !bus.msg2_valid;
                if (req_fire && supported) begin
                    state_d = RESP;
                end
            end
            RESP: begin
                bus.msg3_valid = 1'b1;
                if (bus.msg3_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Line storage: a hit updates the state at acceptance; fills only happen
    // when no request is presented, so the two never collide.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            line_tag_q   <= '0;
            line_data_q  <= '0;
            line_state_q <= ST_I;
        end else if (req_fire && supported) begin
            if (hit) begin
                line_state_q <= hit_next_state;
            end
        end else if (fill_fire) begin
            line_tag_q   <= bus.fill_tag;
            line_data_q  <= bus.fill_data;
            line_state_q <= bus.fill_state;
        end
    end

    // Ack payload is captured once at acceptance and held through RESP, which
    // keeps it stable under backpressure.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            msg3_type_q <= '0;
            msg3_tag_q  <= '0;
            msg3_data_q <= '0;
            err_q       <= 1'b0;
        end else begin
            err_q <= req_fire && !supported;
            if (req_fire && supported) begin
                msg3_type_q <= ack_type;
                msg3_tag_q  <= bus.msg2_tag;
                msg3_data_q <= hit ? line_data_q : 64'h0;
            end
        end
    end

    assign bus.msg3_type   = msg3_type_q;
    assign bus.msg3_tag    = msg3_tag_q;
    assign bus.msg3_source = NODE_ID;
    assign bus.msg3_data   = msg3_data_q;
    assign line_state      = line_state_q;
    assign err_pulse       = err_q;

endmodule

// File: tb/tb_pmesh_l1_fwd_responder.sv
module tb_pmesh_l1_fwd_responder;

    localparam logic [5:0] NODE = 6'd21;

    logic       clk = 1'b0;
    logic       rst;
    logic [1:0] line_state;
    logic       err_pulse;

    int checks = 0;
    int errors = 0;

    pmesh_l1_fwd_responder_if bus ();

    pmesh_l1_fwd_responder #(.NODE_ID(NODE)) dut (
        .clk        (clk),
        .rst        (rst),
        .bus        (bus.slave),
        .line_state (line_state),
        .err_pulse  (err_pulse)
    );

    always #5 clk = ~clk;

`ifdef PMESH_L1_LOAD_FWD_EN
    localparam bit LOAD_EN = 1'b1;
`else
    localparam bit LOAD_EN = 1'b0;
`endif

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: one cache line plus an optional pending ack.
    logic [25:0] m_tag;
    logic [63:0] m_data;
    logic [1:0]  m_st;
    bit          m_pending;
    logic [7:0]  m_ack_type;
    logic [25:0] m_ack_tag;
    logic [63:0] m_ack_data;
    bit          m_err;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_tag = '0; m_data = '0; m_st = 2'd0;
            m_pending = 0; m_err = 0;
            m_ack_type = '0; m_ack_tag = '0; m_ack_data = '0;
        end else begin
            m_err = 0;
            if (m_pending) begin
                if (bus.msg3_ready) m_pending = 0;
            end else if (bus.msg2_valid) begin
                bit is_hit;
                is_hit = (m_st != 2'd0) && (bus.msg2_tag == m_tag);
                if (bus.msg2_type == 8'h15 || (LOAD_EN && bus.msg2_type == 8'h13)) begin
                    m_pending  = 1;
                    m_ack_type = (bus.msg2_type == 8'h15) ? 8'h16 : 8'h14;
                    m_ack_tag  = bus.msg2_tag;
                    m_ack_data = is_hit ? m_data : 64'h0;
                    if (is_hit) m_st = (bus.msg2_type == 8'h15) ? 2'd0 : 2'd1;
                end else begin
                    m_err = 1;
                end
            end else if (bus.fill_valid) begin
                m_tag = bus.fill_tag; m_data = bus.fill_data; m_st = bus.fill_state;
            end
        end
    end

    always @(negedge clk) begin
        chk("msg2_ready", bus.msg2_ready, !rst && !m_pending);
        chk("fill_ready", bus.fill_ready, !rst && !m_pending && !bus.msg2_valid);
        chk("msg3_valid", bus.msg3_valid, m_pending);
        chk("line_state", line_state, m_st);
        chk("err_pulse", err_pulse, m_err);
        if (m_pending) begin
            chk("msg3_type", bus.msg3_type, m_ack_type);
            chk("msg3_tag", bus.msg3_tag, m_ack_tag);
            chk("msg3_source", bus.msg3_source, NODE);
            chk("msg3_data", bus.msg3_data, m_ack_data);
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic do_fill(input logic [25:0] t, input logic [63:0] d, input logic [1:0] s);
        bus.fill_valid = 1; bus.fill_tag = t; bus.fill_data = d; bus.fill_state = s;
        tick(1);
        bus.fill_valid = 0;
    endtask

    task automatic send_req(input logic [7:0] ty, input logic [25:0] t);
        bus.msg2_valid = 1; bus.msg2_type = ty; bus.msg2_tag = t;
        tick(1);
        bus.msg2_valid = 0;
    endtask

    initial begin
        rst = 1;
        bus.msg2_valid = 0; bus.msg2_type = '0; bus.msg2_tag = '0;
        bus.msg3_ready = 0;
        bus.fill_valid = 0; bus.fill_tag = '0; bus.fill_data = '0; bus.fill_state = '0;
        tick(2);
        chk("rst_line_state", line_state, 2'd0);
        chk("rst_msg3_valid", bus.msg3_valid, 1'b0);
        chk("rst_msg2_ready", bus.msg2_ready, 1'b0);
        chk("rst_msg3_data", bus.msg3_data, 64'h0);
        rst = 0;
        tick(1);

        // STORE_FWD hit on an M line
        do_fill(26'h123, 64'hDEAD_BEEF_0000_0001, 2'd3);
        chk("fill_m_state", line_state, 2'd3);
        send_req(8'h15, 26'h123);
        chk("hit_valid", bus.msg3_valid, 1'b1);
        chk("hit_type", bus.msg3_type, 8'h16);
        chk("hit_tag", bus.msg3_tag, 26'h123);
        chk("hit_source", bus.msg3_source, NODE);
        chk("hit_data", bus.msg3_data, 64'hDEAD_BEEF_0000_0001);
        chk("hit_line_state", line_state, 2'd0);
        bus.msg3_ready = 1; tick(1); bus.msg3_ready = 0;
        chk("hit_done", bus.msg3_valid, 1'b0);

        // STORE_FWD miss on an E line
        do_fill(26'h123, 64'h0000_0000_CAFE_0002, 2'd2);
        send_req(8'h15, 26'h456);
        chk("miss_type", bus.msg3_type, 8'h16);
        chk("miss_data", bus.msg3_data, 64'h0);
        chk("miss_line_state", line_state, 2'd2);
        bus.msg3_ready = 1; tick(1); bus.msg3_ready = 0;

        // Backpressure: five stalled cycles, fields stable, no new request taken
        do_fill(26'h077, 64'h1111_2222_3333_4444, 2'd3);
        send_req(8'h15, 26'h077);
        for (int i = 0; i < 5; i++) begin
            chk("bp_valid", bus.msg3_valid, 1'b1);
            chk("bp_type", bus.msg3_type, 8'h16);
            chk("bp_tag", bus.msg3_tag, 26'h077);
            chk("bp_data", bus.msg3_data, 64'h1111_2222_3333_4444);
            chk("bp_msg2_ready", bus.msg2_ready, 1'b0);
            tick(1);
        end
        bus.msg3_ready = 1; tick(1); bus.msg3_ready = 0;
        chk("bp_idle_valid", bus.msg3_valid, 1'b0);
        chk("bp_idle_ready", bus.msg2_ready, 1'b1);

        // Priority: request wins over a simultaneous fill
        do_fill(26'h0AA, 64'h5555_0000_0000_0005, 2'd2);
        bus.fill_valid = 1; bus.fill_tag = 26'h0BB; bus.fill_data = 64'h6666; bus.fill_state = 2'd1;
        bus.msg2_valid = 1; bus.msg2_type = 8'h15; bus.msg2_tag = 26'h0CC;
        #1;
        chk("prio_fill_ready", bus.fill_ready, 1'b0);
        chk("prio_msg2_ready", bus.msg2_ready, 1'b1);
        tick(1);
        bus.msg2_valid = 0;
        tick(2);
        chk("prio_fill_blocked", line_state, 2'd2);
        bus.msg3_ready = 1; tick(1); bus.msg3_ready = 0;
        chk("prio_fill_ready_after", bus.fill_ready, 1'b1);
        tick(1);
        bus.fill_valid = 0;
        chk("prio_fill_done", line_state, 2'd1);

        // Reset while an ack is pending
        do_fill(26'h200, 64'h7777_8888_9999_AAAA, 2'd3);
        send_req(8'h15, 26'h201);
        chk("rr_valid", bus.msg3_valid, 1'b1);
        #1 rst = 1;
        #1;
        chk("rr_async_valid", bus.msg3_valid, 1'b0);
        chk("rr_async_state", line_state, 2'd0);
        tick(1);
        rst = 0;
        bus.msg3_ready = 1;
        tick(3);
        chk("rr_no_ack", bus.msg3_valid, 1'b0);
        bus.msg3_ready = 0;

        // LOAD_FWD to a hit M line
        do_fill(26'h300, 64'h0123_4567_89AB_CDEF, 2'd3);
        send_req(8'h13, 26'h300);
`ifdef PMESH_L1_LOAD_FWD_EN
        chk("ld_valid", bus.msg3_valid, 1'b1);
        chk("ld_type", bus.msg3_type, 8'h14);
        chk("ld_data", bus.msg3_data, 64'h0123_4567_89AB_CDEF);
        chk("ld_line_state", line_state, 2'd1);
        bus.msg3_ready = 1; tick(1); bus.msg3_ready = 0;
`else
        chk("ld_err", err_pulse, 1'b1);
        chk("ld_no_msg3", bus.msg3_valid, 1'b0);
        chk("ld_line_state", line_state, 2'd3);
        tick(1);
        chk("ld_err_clear", err_pulse, 1'b0);
`endif

        // Unsupported type
        send_req(8'h55, 26'h300);
        chk("unsup_err", err_pulse, 1'b1);
        chk("unsup_no_msg3", bus.msg3_valid, 1'b0);
        tick(1);
        chk("unsup_err_clear", err_pulse, 1'b0);
        chk("unsup_idle", bus.msg2_ready, 1'b1);

        tick(2);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/pmesh_l1_fwd_responder.md
PMESH_L1_FWD_RESPONDER -- requirements
Module: pmesh_l1_fwd_responder

Interface
REQ-001 SHALL have parameter NODE_ID, default 6'd0, this L1's node id placed in msg3_source.
REQ-002 SHALL have port clk, input, 1 bit: single clock; all state on posedge clk.
REQ-003 SHALL have port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-004 SHALL have port msg2_valid, input, 1 bit: L2-to-L1 forward request valid.
REQ-005 SHALL have port msg2_ready, output, 1 bit: request accepted when msg2_valid and msg2_ready are both high.
REQ-006 SHALL have port msg2_type, input, 8 bits: request type.
REQ-007 SHALL have port msg2_tag, input, 26 bits: requested line tag.
REQ-008 SHALL have port msg3_valid, output, 1 bit: L1-to-L2 ack valid.
REQ-009 SHALL have port msg3_ready, input, 1 bit: L2 accepts the ack.
REQ-010 SHALL have port msg3_type, output, 8 bits: ack type.
REQ-011 SHALL have port msg3_tag, output, 26 bits: echoed request tag.
REQ-012 SHALL have port msg3_source, output, 6 bits: equals NODE_ID.
REQ-013 SHALL have port msg3_data, output, 64 bits: line data.
REQ-014 SHALL have port fill_valid, input, 1 bit: local line install.
REQ-015 SHALL have port fill_ready, output, 1 bit: install accepted when fill_valid and fill_ready are both high.
REQ-016 SHALL have port fill_tag, input, 26 bits: tag to install.
REQ-017 SHALL have port fill_data, input, 64 bits: data to install.
REQ-018 SHALL have port fill_state, input, 2 bits: line state to install.
REQ-019 SHALL have port line_state, output, 2 bits: current line state.
REQ-020 SHALL have port err_pulse, output, 1 bit: one-cycle pulse on an unsupported request type.

Function
REQ-021 SHALL hold one line: tag[25:0], data[63:0], state[1:0]; line states are I=0, S=1, E=2, M=3.
REQ-022 SHALL use message types STORE_FWD=8'h15, STORE_FWDACK=8'h16, LOAD_FWD=8'h13, LOAD_FWDACK=8'h14.
REQ-023 SHALL run a two-state FSM: IDLE and RESP.
REQ-024 SHALL drive msg2_ready=1 only in IDLE; msg3_valid=1 only in RESP.
REQ-025 SHALL capture an accepted request's tag and type and enter RESP on the next cycle, so msg3_valid rises exactly one cycle after acceptance.
REQ-026 SHALL define a hit as msg2_tag==line tag and line state!=I, evaluated at acceptance.
REQ-027 SHALL, for STORE_FWD: set msg3_type=8'h16; set msg3_data=line data on a hit, else 64'h0; on a hit, move the line state to I at acceptance.
REQ-028 SHALL hold msg3_type, msg3_tag, msg3_source and msg3_data constant while msg3_valid=1 and msg3_ready=0.
REQ-029 SHALL return to IDLE in the cycle msg3_valid and msg3_ready are both high; no new request is accepted in that same cycle.
REQ-030 SHALL drive fill_ready=1 only when the FSM is IDLE and msg2_valid=0, so a forward request always has priority over a fill.
REQ-031 SHALL, on an accepted fill, overwrite the line tag, data and state on the next edge.
REQ-032 SHALL, on a miss, leave the line unchanged.
REQ-033 SHALL, for any unsupported type: accept the request, raise no msg3, pulse err_pulse for one cycle, and stay in IDLE.

Reset
REQ-034 SHALL, on rst assertion and independent of clk, force: FSM=IDLE; line state=I; line tag=0; line data=0; msg3_valid=0; msg3_type=0; msg3_tag=0; msg3_data=0; err_pulse=0.
REQ-035 SHALL, when rst is asserted in RESP, drop the pending ack without completing it.
REQ-036 SHALL hold msg2_ready=0 and fill_ready=0 while rst=1.

Configuration
REQ-037 SHALL gate LOAD_FWD handling on macro PMESH_L1_LOAD_FWD_EN.
- Macro defined: LOAD_FWD gets msg3_type=8'h14, data on a hit (else 0), and the line state becomes S on a hit.
- Macro undefined: LOAD_FWD is an unsupported type (REQ-033).

Verification
REQ-038 SHALL cover STORE_FWD hit: fill tag=0x123, data=0xDEAD_BEEF_0000_0001, state=M; then STORE_FWD tag=0x123 -> one cycle later msg3 carries type 0x16, tag 0x123, source NODE_ID, data 0xDEAD_BEEF_0000_0001; line_state=0.
REQ-039 SHALL cover STORE_FWD miss: line tag=0x123 state=E; STORE_FWD tag=0x456 -> msg3 data=0, type 0x16; line_state remains 2.
REQ-040 SHALL cover backpressure: msg3_ready=0 for 5 cycles -> msg3 fields stable and msg2_ready=0 throughout; ack completes on the first ready cycle; IDLE the next cycle.
REQ-041 SHALL cover priority: fill_valid and msg2_valid both high in IDLE -> request accepted, fill_ready=0; the fill is accepted only after the ack completes.
REQ-042 SHALL cover reset mid-RESP: rst pulsed while msg3_valid=1 -> msg3_valid=0 immediately, line_state=0, no ack after rst release.
REQ-043 SHALL cover LOAD_FWD to a hit M line: macro defined -> type 0x14, line_state=1; macro undefined -> err_pulse for one cycle, no msg3, line unchanged.
